axi_lite_arbiter_2to1: RTL and testbench
========================================

Name: axi_lite_arbiter_2to1

Overview:
- Shares the core's single AXI4-Lite master port between two requesters: slave port 0 (instruction fetch) and slave port 1 (load/store data).
- Sits between the fetch/LSU AXI masters inside riscv_top and the external axi_interface.
- Serializes whole transactions: one outstanding read or write at a time.
- Round-robin arbitration between requesters.

Parameters:
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of R/W channels; strobe width is DATA_W/8

Ports:
(sN = s0 and s1, same set each; widths A=ADDR_W, D=DATA_W, S=DATA_W/8)
- m_axi_aclk  in  1  single clock for all logic
- m_axi_aresetn  in  1  synchronous, active-low reset
- sN_arvalid in 1, sN_araddr in A, sN_arready out 1  requester read address
- sN_rvalid out 1, sN_rdata out D, sN_rresp out 2, sN_rready in 1  requester read data
- sN_awvalid in 1, sN_awaddr in A, sN_awready out 1  requester write address
- sN_wvalid in 1, sN_wdata in D, sN_wstrb in S, sN_wready out 1  requester write data
- sN_bvalid out 1, sN_bresp out 2, sN_bready in 1  requester write response
- m_arvalid out 1, m_araddr out A, m_arready in 1  downstream read address
- m_rvalid in 1, m_rdata in D, m_rresp in 2, m_rready out 1  downstream read data
- m_awvalid out 1, m_awaddr out A, m_awready in 1  downstream write address
- m_wvalid out 1, m_wdata out D, m_wstrb out S, m_wready in 1  downstream write data
- m_bvalid in 1, m_bresp in 2, m_bready out 1  downstream write response

Behaviour:
- Clock and reset: one clock, m_axi_aclk. Reset m_axi_aresetn is synchronous and active-low.
- Reset values:
  - All valid/ready outputs on both sides are 0.
  - Address, data and strobe outputs are 0.
  - FSM is in IDLE; grant is none; rr_last = 1, so s0 wins first.
- Request detection per requester: req_N = sN_arvalid | (sN_awvalid & sN_wvalid). Within one requester, a read beats a write.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE:
  - If any req_N is set, register grant and type, then go to RD_ADDR or WR_ADDR.
  - On contention, grant the requester != rr_last.
  - All forwarding is off in IDLE. Arbitration costs exactly one cycle: a request seen at cycle t gives m_arvalid/m_awvalid at t+1.
- Forwarding while granted:
  - Granted requester's valid, address, data and strobe are muxed combinationally to m_*.
  - Downstream readies and responses are routed only to the granted requester.
  - The non-granted requester sees all ready/valid = 0.
- RD_ADDR: forward AR. On m_arvalid & m_arready, go to RD_DATA.
- RD_DATA:
  - Forward R: rdata and rresp are passed unchanged; m_rready = sN_rready.
  - On the R handshake: set rr_last = grant and go to IDLE.
- WR_ADDR:
  - Forward AW and W independently. Sticky aw_done / w_done flags mask each valid once its handshake completes.
  - Go to WR_RESP when both are done; handshakes may land in the same cycle.
- WR_RESP: forward B. On the B handshake: set rr_last = grant, clear the flags, go to IDLE.
- Minimum transaction length is 3 cycles. There is at least one IDLE cycle between transactions.
- Requesters must hold valid and payload stable until the handshake (AXI rule). Dropping valid after grant is unsupported.
- Reset mid-transaction:
  - Next cycle the block is in reset state and the transaction is abandoned.
  - The downstream slave shares aresetn and is reset too.
- Response codes (OKAY/SLVERR/DECERR) are passed through unmodified; the arbiter never generates them.

Optional Feature:
- Macro: AXI_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority, s1 (data) always wins contention.
  - rr_last is not implemented.
  - s0 can starve under continuous s1 traffic.
- Undefined: round-robin as described in Behaviour.

Test Plan:
1. s0 read 0x100 after reset; slave returns 0xDEADBEEF/OKAY with arready=1 → m_arvalid 1 cycle after s0_arvalid; s0_rdata = 0xDEADBEEF, rresp = 0; s1 sees no valid/ready.
2. s0 and s1 both request reads in the same cycle, twice:
   - 1st round: s0 served first, then s1.
   - 2nd round: s1 served first.
   - m_araddr never mixes addresses.
3. s1 write 0x200 / 0xA5A5A5A5, wstrb 0xF; m_awready in cycle 1, m_wready 3 cycles later → exactly one AW and one W handshake; s1_bvalid once with bresp = 0; FSM stays in WR_ADDR until W completes.
4. s0 read with s0_rready held low 5 cycles while m_rvalid = 1 → m_rready low, R held stable, handshake on cycle 6, then IDLE.
5. m_axi_aresetn low during RD_DATA → next cycle all outputs 0, FSM IDLE; after release, a fresh s1 read of 0x300 completes normally.
6. AXI_ARB_FIXED_PRIO_EN defined, s0 and s1 requesting reads continuously for 4 transactions → all 4 granted to s1; s0_arready stays 0.

Source files
------------

// File: rtl/axi_lite_arbiter_2to1.sv
// axi_lite_arbiter_2to1: serializes two AXI4-Lite requesters onto one master port, round-robin.
// Define AXI_ARB_FIXED_PRIO_EN to give s1 fixed priority instead.
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  s0_arvalid,
    input  logic [ADDR_W-1:0]     s0_araddr,
    output logic                  s0_arready,
    output logic                  s0_rvalid,
    output logic [DATA_W-1:0]     s0_rdata,
    output logic [1:0]            s0_rresp,
    input  logic                  s0_rready,
    input  logic                  s0_awvalid,
    input  logic [ADDR_W-1:0]     s0_awaddr,
    output logic                  s0_awready,
    input  logic                  s0_wvalid,
    input  logic [DATA_W-1:0]     s0_wdata,
    input  logic [DATA_W/8-1:0]   s0_wstrb,
    output logic                  s0_wready,
    output logic                  s0_bvalid,
    output logic [1:0]            s0_bresp,
    input  logic                  s0_bready,
    input  logic                  s1_arvalid,
    input  logic [ADDR_W-1:0]     s1_araddr,
    output logic                  s1_arready,
    output logic                  s1_rvalid,
    output logic [DATA_W-1:0]     s1_rdata,
    output logic [1:0]            s1_rresp,
    input  logic                  s1_rready,
    input  logic                  s1_awvalid,
    input  logic [ADDR_W-1:0]     s1_awaddr,
    output logic                  s1_awready,
    input  logic                  s1_wvalid,
    input  logic [DATA_W-1:0]     s1_wdata,
    input  logic [DATA_W/8-1:0]   s1_wstrb,
    output logic                  s1_wready,
    output logic                  s1_bvalid,
    output logic [1:0]            s1_bresp,
    input  logic                  s1_bready,
    output logic                  m_arvalid,
    output logic [ADDR_W-1:0]     m_araddr,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    output logic                  m_rready,
    output logic                  m_awvalid,
    output logic [ADDR_W-1:0]     m_awaddr,
    input  logic                  m_awready,
    output logic                  m_wvalid,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    output logic                  m_bready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
    state_t r_state;
    logic   r_grant, r_aw_done, r_w_done;
    logic   w_req0, w_req1, w_pick, w_pick_rd;
    logic   w_rd_a, w_rd_d, w_wr_a, w_wr_r, w_g0_rd, w_g1_rd, w_g0_wr, w_g1_wr;
    logic   w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;

    assign w_req0    = s0_arvalid | (s0_awvalid & s0_wvalid);
    assign w_req1    = s1_arvalid | (s1_awvalid & s1_wvalid);
    assign w_pick_rd = w_pick ? s1_arvalid : s0_arvalid;

    assign w_rd_a  = r_state == RD_ADDR;
    assign w_rd_d  = r_state == RD_DATA;
    assign w_wr_a  = r_state == WR_ADDR;
    assign w_wr_r  = r_state == WR_RESP;
    assign w_g0_rd = w_rd_d & ~r_grant;
    assign w_g1_rd = w_rd_d & r_grant;
    assign w_g0_wr = w_wr_r & ~r_grant;
    assign w_g1_wr = w_wr_r & r_grant;

    assign m_arvalid = w_rd_a & (r_grant ? s1_arvalid : s0_arvalid);
    assign m_araddr  = w_rd_a ? (r_grant ? s1_araddr : s0_araddr) : '0;
    assign m_rready  = w_rd_d & (r_grant ? s1_rready : s0_rready);
    assign m_awvalid = w_wr_a & ~r_aw_done & (r_grant ? s1_awvalid : s0_awvalid);
    assign m_awaddr  = w_wr_a ? (r_grant ? s1_awaddr : s0_awaddr) : '0;
    assign m_wvalid  = w_wr_a & ~r_w_done & (r_grant ? s1_wvalid : s0_wvalid);
    assign m_wdata   = w_wr_a ? (r_grant ? s1_wdata : s0_wdata) : '0;
    assign m_wstrb   = w_wr_a ? (r_grant ? s1_wstrb : s0_wstrb) : '0;
    assign m_bready  = w_wr_r & (r_grant ? s1_bready : s0_bready);

    // Downstream readies and responses reach only the granted requester
    assign s0_arready = w_rd_a & ~r_grant & m_arready;
    assign s0_rvalid  = w_g0_rd & m_rvalid;
    assign s0_rdata   = w_g0_rd ? m_rdata : '0;
    assign s0_rresp   = w_g0_rd ? m_rresp : 2'b00;
    assign s0_awready = w_wr_a & ~r_aw_done & ~r_grant & m_awready;
    assign s0_wready  = w_wr_a & ~r_w_done & ~r_grant & m_wready;
    assign s0_bvalid  = w_g0_wr & m_bvalid;
    assign s0_bresp   = w_g0_wr ? m_bresp : 2'b00;
    assign s1_arready = w_rd_a & r_grant & m_arready;
    assign s1_rvalid  = w_g1_rd & m_rvalid;
    assign s1_rdata   = w_g1_rd ? m_rdata : '0;
    assign s1_rresp   = w_g1_rd ? m_rresp : 2'b00;
    assign s1_awready = w_wr_a & ~r_aw_done & r_grant & m_awready;
    assign s1_wready  = w_wr_a & ~r_w_done & r_grant & m_wready;
    assign s1_bvalid  = w_g1_wr & m_bvalid;
    assign s1_bresp   = w_g1_wr ? m_bresp : 2'b00;

    assign w_ar_hs = m_arvalid & m_arready;
    assign w_r_hs  = m_rvalid & m_rready;
    assign w_aw_hs = m_awvalid & m_awready;
    assign w_w_hs  = m_wvalid & m_wready;
    assign w_b_hs  = m_bvalid & m_bready;

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign w_pick = w_req1;
`else
    logic r_rr_last;
    assign w_pick = (w_req0 & w_req1) ? ~r_rr_last : w_req1;
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) r_rr_last <= 1'b1;
        else if (w_r_hs | w_b_hs) r_rr_last <= r_grant;
    end
`endif

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_req0 | w_req1) begin
                    r_grant <= w_pick;
                    r_state <= w_pick_rd ? RD_ADDR : WR_ADDR;
                end
                RD_ADDR: if (w_ar_hs) r_state <= RD_DATA;
                RD_DATA: if (w_r_hs) r_state <= IDLE;
                WR_ADDR: begin
                    r_aw_done <= r_aw_done | w_aw_hs;
                    r_w_done  <= r_w_done | w_w_hs;
                    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_state <= WR_RESP;
                end
                WR_RESP: if (w_b_hs) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// tb_axi_lite_arbiter_2to1: directed checks of the 2:1 AXI4-Lite arbiter.
module tb_axi_lite_arbiter_2to1;
    logic        clk, m_axi_aresetn;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_awvalid, s0_awready;
    logic        s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic [31:0] s0_araddr, s0_rdata, s0_awaddr, s0_wdata;
    logic [3:0]  s0_wstrb;
    logic [1:0]  s0_rresp, s0_bresp;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_awvalid, s1_awready;
    logic        s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic [31:0] s1_araddr, s1_rdata, s1_awaddr, s1_wdata;
    logic [3:0]  s1_wstrb;
    logic [1:0]  s1_rresp, s1_bresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic        m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_rresp, m_bresp;
    logic [14:0] w_ctl;
    int          n_chk = 0, n_fail = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    axi_lite_arbiter_2to1 dut (
        .m_axi_aclk(clk), .m_axi_aresetn(m_axi_aresetn),
        .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arready(s0_arready),
        .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rready(s0_rready),
        .s0_awvalid(s0_awvalid), .s0_awaddr(s0_awaddr), .s0_awready(s0_awready),
        .s0_wvalid(s0_wvalid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wready(s0_wready),
        .s0_bvalid(s0_bvalid), .s0_bresp(s0_bresp), .s0_bready(s0_bready),
        .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arready(s1_arready),
        .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rready(s1_rready),
        .s1_awvalid(s1_awvalid), .s1_awaddr(s1_awaddr), .s1_awready(s1_awready),
        .s1_wvalid(s1_wvalid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wready(s1_wready),
        .s1_bvalid(s1_bvalid), .s1_bresp(s1_bresp), .s1_bready(s1_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready)
    );

    assign w_ctl = {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                    s0_arready, s0_rvalid, s0_awready, s0_wready, s0_bvalid,
                    s1_arready, s1_rvalid, s1_awready, s1_wready, s1_bvalid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_awvalid && m_awready) aw_cnt++;
        if (m_wvalid && m_wready) w_cnt++;
        if (s1_bvalid && s1_bready) b_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        m_axi_aresetn = 1'b0;
        tick();
        tick();
        m_axi_aresetn = 1'b1;
    endtask

    // Drives one read through from IDLE; the requester p must already be asserting arvalid
    task automatic serve_read(input logic p, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        #1 check("rd_idle_arvalid", m_arvalid, 1'b0);
        tick();
        #1 check("rd_arvalid", m_arvalid, 1'b1);
        check("rd_araddr", m_araddr, a);
        check("rd_arready_grant", p ? s1_arready : s0_arready, 1'b1);
        check("rd_arready_other", p ? s0_arready : s1_arready, 1'b0);
        tick();
        if (p) s1_arvalid = 1'b0;
        else s0_arvalid = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = d;
        m_rresp  = r;
        #1 check("rd_rvalid_grant", p ? s1_rvalid : s0_rvalid, 1'b1);
        check("rd_rdata", p ? s1_rdata : s0_rdata, d);
        check("rd_rresp", p ? s1_rresp : s0_rresp, r);
        check("rd_rvalid_other", p ? s0_rvalid : s1_rvalid, 1'b0);
        tick();
        m_rvalid = 1'b0;
    endtask

    initial begin
        int  aw0, w0, b0;
        logic p;
        {s0_arvalid, s0_awvalid, s0_wvalid, s1_arvalid, s1_awvalid, s1_wvalid} = '0;
        {s0_araddr, s0_awaddr, s0_wdata, s1_araddr, s1_awaddr, s1_wdata} = '0;
        s0_wstrb = '0; s1_wstrb = '0;
        {s0_rready, s0_bready, s1_rready, s1_bready} = 4'hF;
        {m_arready, m_awready, m_wready} = 3'b100;
        {m_rvalid, m_bvalid} = '0;
        m_rdata = '0; m_rresp = '0; m_bresp = '0;

        m_axi_aresetn = 1'b0;
        tick();
        #1 check("rst_ctl", w_ctl, 15'h0);
        check("rst_araddr", m_araddr, 32'h0);
        check("rst_wdata", m_wdata, 32'h0);
        m_axi_aresetn = 1'b1;
        tick();

        s0_arvalid = 1'b1; s0_araddr = 32'h100;
        serve_read(1'b0, 32'h100, 32'hDEADBEEF, 2'b00);

        do_reset();
        s0_arvalid = 1'b1; s0_araddr = 32'h10;
        s1_arvalid = 1'b1; s1_araddr = 32'h20;
        serve_read(1'b0, 32'h10, 32'h11, 2'b00);
        s0_arvalid = 1'b1; s0_araddr = 32'h14;
        serve_read(1'b1, 32'h20, 32'h22, 2'b00);
        serve_read(1'b0, 32'h14, 32'h33, 2'b01);

        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        s1_awvalid = 1'b1; s1_awaddr = 32'h200;
        s1_wvalid = 1'b1; s1_wdata = 32'hA5A5A5A5; s1_wstrb = 4'hF;
        m_awready = 1'b0; m_wready = 1'b0;
        #1 check("wr_idle_awvalid", m_awvalid, 1'b0);
        tick();
        m_awready = 1'b1;
        #1 check("wr_awvalid", m_awvalid, 1'b1);
        check("wr_awaddr", m_awaddr, 32'h200);
        check("wr_wvalid", m_wvalid, 1'b1);
        check("wr_wdata", m_wdata, 32'hA5A5A5A5);
        check("wr_wstrb", m_wstrb, 4'hF);
        check("wr_awready", s1_awready, 1'b1);
        check("wr_wready_early", s1_wready, 1'b0);
        check("wr_s0_awready", s0_awready, 1'b0);
        tick();
        s1_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 check("wr_aw_masked", m_awvalid, 1'b0);
            check("wr_wait_wvalid", m_wvalid, 1'b1);
            check("wr_stay_addr", m_bready, 1'b0);
            tick();
        end
        m_wready = 1'b1;
        #1 check("wr_wready", s1_wready, 1'b1);
        tick();
        s1_wvalid = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b1; m_bresp = 2'b00;
        #1 check("wr_bvalid", s1_bvalid, 1'b1);
        check("wr_bresp", s1_bresp, 2'b00);
        check("wr_s0_bvalid", s0_bvalid, 1'b0);
        check("wr_wvalid_done", m_wvalid, 1'b0);
        tick();
        m_bvalid = 1'b0;
        #1 check("wr_idle_bvalid", s1_bvalid, 1'b0);
        check("wr_aw_count", aw_cnt - aw0, 1);
        check("wr_w_count", w_cnt - w0, 1);
        check("wr_b_count", b_cnt - b0, 1);

        s0_arvalid = 1'b1; s0_araddr = 32'h400; s0_rready = 1'b0;
        #1 check("bp_idle_arvalid", m_arvalid, 1'b0);
        tick();
        #1 check("bp_arvalid", m_arvalid, 1'b1);
        check("bp_araddr", m_araddr, 32'h400);
        tick();
        s0_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h12345678; m_rresp = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_rready_low", m_rready, 1'b0);
            check("bp_rvalid_held", s0_rvalid, 1'b1);
            check("bp_rdata_held", s0_rdata, 32'h12345678);
            tick();
        end
        s0_rready = 1'b1;
        #1 check("bp_rready", m_rready, 1'b1);
        check("bp_rresp", s0_rresp, 2'b10);
        tick();
        #1 check("bp_idle_rvalid", s0_rvalid, 1'b0);
        check("bp_idle_arvalid2", m_arvalid, 1'b0);
        m_rvalid = 1'b0;

        s1_arvalid = 1'b1; s1_araddr = 32'h500;
        tick();
        tick();
        s1_arvalid = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hCAFE;
        #1 check("mr_rvalid_pre", s1_rvalid, 1'b1);
        m_axi_aresetn = 1'b0;
        tick();
        #1 check("mr_rst_ctl", w_ctl, 15'h0);
        check("mr_rst_rdata", s1_rdata, 32'h0);
        m_axi_aresetn = 1'b1; m_rvalid = 1'b0;
        s1_arvalid = 1'b1; s1_araddr = 32'h300;
        serve_read(1'b1, 32'h300, 32'h3003, 2'b00);

        do_reset();
        s0_arvalid = 1'b1; s0_araddr = 32'h600;
        s1_arvalid = 1'b1; s1_araddr = 32'h700;
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
            p = 1'b1;
`else
            p = i[0];
`endif
            serve_read(p, p ? 32'h700 : 32'h600, 32'h1000 + i, 2'b00);
            s0_arvalid = 1'b1;
            s1_arvalid = 1'b1;
        end
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
